// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake: single-cycle logic/arith ops and
// an iterative shift-add unsigned multiplier producing a double-width product.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLTU = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg, acc_reg, acc_sum;
  logic [WIDTH-1:0]     mplier_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [WIDTH-1:0]     sum, diff, alu_res;
  logic                 alu_ovf;
  logic                 accept, accept_alu, accept_mul, mul_last;

  assign accept     = (state_reg == IDLE) && start;
  assign accept_mul = accept && (op == OP_MUL);
  assign accept_alu = accept && (op != OP_MUL);
  assign mul_last   = (state_reg == MUL) && (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept_mul) state_next = MUL;
      MUL:     if (mul_last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == MUL);
  end

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      default: alu_res = '0;
    endcase
  end

  // Multiplicand shifts left and multiplier right, so bit 0 is always bit cnt.
  always_comb begin
    acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      result     <= '0;
      result_hi  <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      done <= 1'b0;
      if (accept_alu) begin
        result    <= alu_res;
        result_hi <= '0;
        zero      <= (alu_res == '0);
        overflow  <= alu_ovf;
        done      <= 1'b1;
      end
      if (accept_mul) begin
        mcand_reg  <= {{WIDTH{1'b0}}, a};
        mplier_reg <= b;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end
      if (state_reg == MUL) begin
        acc_reg    <= acc_sum;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + CNT_W'(1);
        if (mul_last) begin
          {result_hi, result} <= acc_sum;
          zero     <= (acc_sum[WIDTH-1:0] == '0);
          overflow <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule
